// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES-side 6502 bus initiator.
// The $402F flag layout is only consumed when MMU_SHADOW_EN is defined.
package nes_bus_pkg;

  localparam int CPU_AW = 16;
  localparam int CPU_DW = 8;

  localparam logic [CPU_AW-1:0] MMU_REG_ADDR = 16'h402F;

  // Bit positions inside mmu_flags (not the $402F data bit numbers).
  localparam int FLAG_EWRAM_00 = 0;
  localparam int FLAG_EWRAM_20 = 1;
  localparam int FLAG_MOVE_PPU = 2;
  localparam int FLAG_ALIAS_00 = 3;
  localparam int FLAG_ALIAS_20 = 4;
  localparam int FLAG_HIDE_PPU = 5;

  localparam logic [5:0] MMU_FLAGS_RESET = 6'b011000;

  typedef struct packed {
    logic [CPU_AW-1:0] addr;
    logic              rw;
    logic [CPU_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/nes_m2_phase_gen.sv
// Free-running bus phase counter and registered M2 generator.
// last_phase/launch are high during the final phase; the edge ending it starts a new bus cycle.
module nes_m2_phase_gen #(
  parameter int CYCLE_CLKS = 12,
  parameter int M2_RISE    = 5
) (
  input  logic clk,
  input  logic rst,
  output logic m2,
  output logic m2_next,
  output logic last_phase,
  output logic launch
);

  localparam int PH_W = $clog2(CYCLE_CLKS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYCLE_CLKS - 1);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(M2_RISE);

  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_next;

  always_comb begin
    last_phase = (ph == PH_LAST);
    launch     = last_phase;
    ph_next    = last_phase ? '0 : ph + PH_W'(1);
    // M2 is a pure function of the phase we are about to enter.
    m2_next    = (ph_next >= PH_RISE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= '0;
      m2 <= 1'b0;
    end else begin
      ph <= ph_next;
      m2 <= m2_next;
    end
  end

endmodule

// File: rtl/nes_bus_master.sv
// CPU-style bus initiator: one-entry request buffer, cycle launch on phase wrap, read response strobe.
// Optional MMU_SHADOW_EN adds mmu_flags, a shadow of the decoder's $402F latch.
module nes_bus_master
  import nes_bus_pkg::*;
#(
  parameter int CYCLE_CLKS = 12,
  parameter int M2_RISE    = 5
) (
  input  logic              SYSCLK,
  input  logic              SYSRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CPU_AW-1:0] req_addr,
  input  logic              req_rw,
  input  logic [CPU_DW-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [CPU_DW-1:0] rsp_rdata,
  output logic              M2,
  output logic [CPU_AW-1:0] CPU_A,
  output logic              CPU_RW,
  output logic [CPU_DW-1:0] CPU_D_OUT,
  output logic              CPU_D_OE,
  input  logic [CPU_DW-1:0] CPU_D_IN,
  output logic              busy
`ifdef MMU_SHADOW_EN
  ,
  output logic [5:0]        mmu_flags
`endif
);

  logic m2_next;
  logic last_phase;
  logic launch;

  nes_m2_phase_gen #(
    .CYCLE_CLKS (CYCLE_CLKS),
    .M2_RISE    (M2_RISE)
  ) u_phase (
    .clk        (SYSCLK),
    .rst        (SYSRST),
    .m2         (M2),
    .m2_next    (m2_next),
    .last_phase (last_phase),
    .launch     (launch)
  );

  req_t req_buf_q;
  logic full_q;
  logic cur_active_q;
  logic accept;
  logic rd_capture;

  always_comb begin
    req_ready  = !full_q || last_phase;
    accept     = req_valid && req_ready;
    busy       = full_q || cur_active_q;
    rd_capture = last_phase && cur_active_q && CPU_RW;
  end

  // Buffer payload carries no reset; full_q alone says whether it is meaningful.
  always_ff @(posedge SYSCLK) begin
    if (accept) begin
      req_buf_q <= '{addr: req_addr, rw: req_rw, wdata: req_wdata};
    end
  end

  // Stage boundary: buffer -> bus cycle at the phase wrap; bus -> response at the same edge.
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      full_q       <= 1'b0;
      cur_active_q <= 1'b0;
      CPU_A        <= '0;
      CPU_RW       <= 1'b1;
      CPU_D_OUT    <= '0;
      CPU_D_OE     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      if (launch) begin
        cur_active_q <= full_q;
        full_q       <= accept;
        if (full_q) begin
          CPU_A     <= req_buf_q.addr;
          CPU_RW    <= req_buf_q.rw;
          CPU_D_OUT <= req_buf_q.wdata;
        end else begin
          CPU_RW    <= 1'b1;
        end
      end else if (accept) begin
        full_q <= 1'b1;
      end

      // m2_next is low on the launch edge, so OE never straddles two cycles.
      CPU_D_OE  <= cur_active_q && !CPU_RW && m2_next;
      rsp_valid <= rd_capture;
      if (rd_capture) begin
        rsp_rdata <= CPU_D_IN;
      end
    end
  end

`ifdef MMU_SHADOW_EN
  logic [5:0] mmu_next;

  always_comb begin
    mmu_next                = '0;
    mmu_next[FLAG_EWRAM_00] = CPU_D_OUT[0];
    mmu_next[FLAG_EWRAM_20] = CPU_D_OUT[1];
    mmu_next[FLAG_MOVE_PPU] = CPU_D_OUT[2];
    mmu_next[FLAG_ALIAS_00] = CPU_D_OUT[4];
    mmu_next[FLAG_ALIAS_20] = CPU_D_OUT[5];
    mmu_next[FLAG_HIDE_PPU] = CPU_D_OUT[6];
  end

  // The launch edge is also the M2 falling edge of the cycle that just ended.
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      mmu_flags <= MMU_FLAGS_RESET;
    end else if (last_phase && cur_active_q && !CPU_RW && (CPU_A == MMU_REG_ADDR)) begin
      mmu_flags <= mmu_next;
    end
  end
`endif

endmodule
